aes_key_schedule: RTL

//  Sequential AES key expansion for AES-128/192/256, one 32-bit word per clock. Expanded

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_sbox_word.sv | 29 ++
 rtl/aes_key_schedule.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: size functions, word/state types, GF(2^8) arithmetic and the
// InvMixColumns column transform used only when AES_KEY_EQINV_EN is defined.
package aes_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Words in the cipher key
  function automatic int unsigned aes_nk(input int unsigned key_bits);
    return key_bits / 32;
  endfunction

  // Number of rounds
  function automatic int unsigned aes_nr(input int unsigned key_bits);
    return (key_bits / 32) + 6;
  endfunction

  // Total expanded words
  function automatic int unsigned aes_nw(input int unsigned key_bits);
    return 4 * ((key_bits / 32) + 7);
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // InvMixColumns on one 32-bit column, byte 0 in [31:24]
  function automatic word_t inv_mix_col(input word_t c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    r1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    r2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    r3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel forward AES S-boxes on a 32-bit word, purely combinational.
// Each S-box is the GF(2^8) inverse (a^254) followed by the FIPS-197 affine map.
module aes_sbox_word
  import aes_pkg::*;
(
  input  word_t din,
  output word_t dout_c
);

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute every byte of the word
  always_comb begin
    dout_c = {sbox_byte(din[31:24]), sbox_byte(din[23:16]),
              sbox_byte(din[15:8]),  sbox_byte(din[7:0])};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expansion, one word per clock, with a random-access
// round-key read port (latency 1).
// Optional feature macro: AES_KEY_EQINV_EN -- rounds 1..NR-1 are returned through
// InvMixColumns for the Equivalent Inverse Cipher.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                keys_rdy,
  input  logic                rk_rd_en,
  input  logic [3:0]          rk_rd_idx,
  output logic                rk_rd_valid,
  output logic                rk_rd_err,
  output logic [127:0]        rk_rd_data
);

  localparam int unsigned NK    = aes_nk(KEY_BITS);
  localparam int unsigned NR    = aes_nr(KEY_BITS);
  localparam int unsigned NW    = aes_nw(KEY_BITS);
  localparam int unsigned IDX_W = 6;
  localparam int unsigned PH_W  = 3;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  state_t           state;
  word_t            win [NK];
  logic [IDX_W-1:0] widx;
  logic [PH_W-1:0]  phase;
  logic [7:0]       rcon;
  word_t            store [NW];

  word_t            sbox_in_c;
  word_t            sbox_out_c;
  word_t            temp_c;
  word_t            new_word_c;
  logic             rd_ok_c;
  logic [IDX_W-1:0] rd_base_c;
  logic [127:0]     rd_raw_c;
  logic [127:0]     rd_word_c;

  aes_sbox_word u_sbox (
    .din    (sbox_in_c),
    .dout_c (sbox_out_c)
  );

  // S-box input: RotWord(w[i-1]) at the start of each NK-word group, else w[i-1]
  always_comb begin
    sbox_in_c = win[NK-1];
    if (phase == '0) sbox_in_c = {win[NK-1][23:0], win[NK-1][31:24]};
  end

  // Next expanded word w[i] = w[i-NK] ^ temp
  always_comb begin
    temp_c = win[NK-1];
    if (phase == '0) begin
      temp_c = sbox_out_c ^ {rcon, 24'h000000};
    end else if (NK == 8 && phase == PH_W'(4)) begin
      temp_c = sbox_out_c;
    end
    new_word_c = win[0] ^ temp_c;
  end

  // Control FSM with sliding window, word index, phase (i mod NK) and Rcon
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      keys_rdy  <= 1'b0;
      widx      <= '0;
      phase     <= '0;
      rcon      <= '0;
      for (int j = 0; j < NK; j++) win[j] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (key_valid) begin
            for (int j = 0; j < NK; j++) win[j] <= key_in[KEY_BITS-1-32*j -: 32];
            state     <= ST_LOAD;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            keys_rdy  <= 1'b0;
          end
        end
        ST_LOAD: begin
          widx  <= IDX_W'(NK);
          phase <= '0;
          rcon  <= 8'h01;
          state <= ST_EXPAND;
        end
        ST_EXPAND: begin
          for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
          win[NK-1] <= new_word_c;
          widx      <= widx + IDX_W'(1);
          phase     <= (phase == PH_W'(NK - 1)) ? '0 : phase + PH_W'(1);
          if (phase == '0) rcon <= xtime(rcon);
          if (widx == IDX_W'(NW - 1)) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            keys_rdy  <= 1'b1;
            key_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word store: key words in LOAD, one expanded word per EXPAND cycle; never cleared
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      for (int j = 0; j < NK; j++) store[j] <= win[j];
    end else if (state == ST_EXPAND) begin
      store[widx] <= new_word_c;
    end
  end

  // Read address decode and round-key assembly
  always_comb begin
    rd_ok_c   = rk_rd_en && keys_rdy && (rk_rd_idx <= 4'(NR));
    rd_base_c = {rk_rd_idx, 2'b00};
    rd_raw_c  = {store[rd_base_c],              store[rd_base_c + IDX_W'(1)],
                 store[rd_base_c + IDX_W'(2)], store[rd_base_c + IDX_W'(3)]};
`ifdef AES_KEY_EQINV_EN
    rd_word_c = rd_raw_c;
    if (rk_rd_idx != '0 && rk_rd_idx != 4'(NR)) begin
      rd_word_c = {inv_mix_col(rd_raw_c[127:96]), inv_mix_col(rd_raw_c[95:64]),
                   inv_mix_col(rd_raw_c[63:32]),  inv_mix_col(rd_raw_c[31:0])};
    end
`else
    rd_word_c = rd_raw_c;
`endif
  end

  // Registered read port; data holds on rejected or idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_rd_valid <= 1'b0;
      rk_rd_err   <= 1'b0;
      rk_rd_data  <= '0;
    end else begin
      rk_rd_valid <= rd_ok_c;
      rk_rd_err   <= rk_rd_en && !rd_ok_c;
      if (rd_ok_c) rk_rd_data <= rd_word_c;
    end
  end

endmodule
